next_pc_unit: RTL and testbench

//   Next-PC selection stage of the single-cycle fetch path. Sign-extended branch

---
 rtl/fetch_pkg.sv | 12 +
 rtl/negedge_reg.sv | 27 ++
 rtl/next_pc_unit.sv | 45 ++++
 tb/tb_next_pc_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path constants: datapath defaults, PC reset value and the
// branch-enable select encodings used by the PC, next-PC and fetch top.
package fetch_pkg;

    localparam int unsigned       WIDTH_DEF       = 32;
    localparam int unsigned       SHIFT_DEF       = 2;
    localparam logic [31:0]       RESET_VALUE_DEF = 32'h0000_0000;

    localparam logic              BE_TAKEN        = 1'b1;
    localparam logic              BE_SEQ          = 1'b0;

endpackage : fetch_pkg

// File: rtl/negedge_reg.sv
// WIDTH-wide register clocked on the falling edge of clk, with a synchronous
// active-high reset that loads RESET_VALUE. Shared by the PC and next-PC paths.
module negedge_reg #(
    parameter int unsigned         WIDTH       = fetch_pkg::WIDTH_DEF,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(negedge clk) begin
        if (rst) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule : negedge_reg

// File: rtl/next_pc_unit.sv
// Next-PC selection: word offset scaled to bytes, added to PC+4, muxed against
// PC+4 by the branch enable and registered on the falling edge of clk.
module next_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         WIDTH       = WIDTH_DEF,
    parameter int unsigned         SHIFT       = SHIFT_DEF,
    parameter logic [WIDTH-1:0]    RESET_VALUE = WIDTH'(RESET_VALUE_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] signal_ext,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic             be,
    output logic [WIDTH-1:0] offset_shift,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] next_pc_d,
    output logic [WIDTH-1:0] next_pc
);

    // Upper SHIFT bits fall off; the add wraps modulo 2^WIDTH, which is what
    // turns a two's-complement offset into a backward target.
    assign offset_shift  = signal_ext << SHIFT;
    assign branch_target = pc_plus4 + offset_shift;

    // NOTE: default assignment first keeps this block latch-free. The if on an
    // equality test also falls to the sequential path when be is X or Z.
    always_comb begin
        next_pc_d = pc_plus4;
        if (be == BE_TAKEN) begin
            next_pc_d = branch_target;
        end
    end

    negedge_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_next_pc_reg (
        .clk (clk),
        .rst (rst),
        .d_i (next_pc_d),
        .q_o (next_pc)
    );

endmodule : next_pc_unit

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios followed by a
// randomized run compared against an arithmetic reference model.
module tb_next_pc_unit;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned SHIFT       = 2;
    localparam logic [31:0] RESET_VALUE = 32'h0;
    localparam logic [31:0] BYTES_PER_WORD = 32'd4;

    logic        clk;
    logic        rst;
    logic [31:0] signal_ext;
    logic [31:0] pc_plus4;
    logic        be;
    logic [31:0] offset_shift;
    logic [31:0] branch_target;
    logic [31:0] next_pc_d;
    logic [31:0] next_pc;

    int n_checks = 0;
    int n_fail   = 0;

    next_pc_unit #(
        .WIDTH       (WIDTH),
        .SHIFT       (SHIFT),
        .RESET_VALUE (RESET_VALUE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .signal_ext    (signal_ext),
        .pc_plus4      (pc_plus4),
        .be            (be),
        .offset_shift  (offset_shift),
        .branch_target (branch_target),
        .next_pc_d     (next_pc_d),
        .next_pc       (next_pc)
    );

    // Falling edges at 5, 15, 25 ...; rising edges at 10, 20, 30 ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: a word offset times the word size, added modulo 2^32.
    function automatic void model(input logic [31:0] se, input logic [31:0] pc,
                                  input logic b, output logic [31:0] os,
                                  output logic [31:0] bt, output logic [31:0] nd);
        os = se * BYTES_PER_WORD;
        bt = pc + os;
        nd = (b === 1'b1) ? bt : pc;
    endfunction

    task automatic drive(input logic r, input logic [31:0] se,
                         input logic [31:0] pc, input logic b);
        @(posedge clk);
        #1;
        rst        = r;
        signal_ext = se;
        pc_plus4   = pc;
        be         = b;
        #1;
    endtask

    task automatic to_fall();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h0, 32'h4, 1'b0);
        to_fall();
        n_checks++;
        if (next_pc !== RESET_VALUE) begin
            n_fail++;
            $display("FAIL reset_value: got %h expected %h", next_pc, RESET_VALUE);
        end
        drive(1'b0, 32'h0, 32'h4, 1'b0);
        to_fall();
        n_checks++;
        if (next_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL seq_after_reset: got %h expected %h", next_pc, 32'h4);
        end
        // Rising edge and input changes before the next falling edge must not move it.
        drive(1'b0, 32'h0, 32'h8, 1'b0);
        n_checks++;
        if (next_pc !== 32'h4) begin
            n_fail++;
            $display("FAIL hold_at_rise: got %h expected %h", next_pc, 32'h4);
        end
    endtask

    task automatic check_scenario(input string name, input logic [31:0] se,
                                  input logic [31:0] pc, input logic b,
                                  input logic [31:0] exp_os, input logic [31:0] exp_bt,
                                  input logic [31:0] exp_pc);
        drive(1'b0, se, pc, b);
        n_checks++;
        if (offset_shift !== exp_os) begin
            n_fail++;
            $display("FAIL %s offset_shift: got %h expected %h", name, offset_shift, exp_os);
        end
        n_checks++;
        if (branch_target !== exp_bt) begin
            n_fail++;
            $display("FAIL %s branch_target: got %h expected %h", name, branch_target, exp_bt);
        end
        n_checks++;
        if (next_pc_d !== exp_pc) begin
            n_fail++;
            $display("FAIL %s next_pc_d: got %h expected %h", name, next_pc_d, exp_pc);
        end
        to_fall();
        n_checks++;
        if (next_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL %s next_pc: got %h expected %h", name, next_pc, exp_pc);
        end
    endtask

    task automatic test_forward();
        check_scenario("forward", 32'h3, 32'h10, 1'b1, 32'hC, 32'h1C, 32'h1C);
    endtask

    task automatic test_backward();
        check_scenario("backward", 32'hFFFF_FFFE, 32'h20, 1'b1, 32'hFFFF_FFF8, 32'h18, 32'h18);
    endtask

    task automatic test_wrap();
        check_scenario("shift_out", 32'h4000_0001, 32'hFFFF_FFFC, 1'b1, 32'h4, 32'h0, 32'h0);
        check_scenario("wrap_plus1", 32'h1, 32'hFFFF_FFFC, 1'b1, 32'h4, 32'h0, 32'h0);
        check_scenario("self_loop", 32'hFFFF_FFFF, 32'h1000, 1'b1, 32'hFFFF_FFFC, 32'hFFC, 32'hFFC);
        check_scenario("not_taken", 32'h7, 32'h200, 1'b0, 32'h1C, 32'h21C, 32'h200);
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 32'h5, 32'h100, 1'b1);
        to_fall();
        n_checks++;
        if (next_pc !== RESET_VALUE) begin
            n_fail++;
            $display("FAIL reset_priority: got %h expected %h", next_pc, RESET_VALUE);
        end
        // Release reset: first falling edge loads the current mux output.
        drive(1'b0, 32'h5, 32'h100, 1'b1);
        to_fall();
        n_checks++;
        if (next_pc !== 32'h114) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", next_pc, 32'h114);
        end
        // be toggles between edges; only its level at the falling edge counts.
        drive(1'b0, 32'h5, 32'h300, 1'b0);
        be = 1'b1;
        #1 be = 1'b0;
        to_fall();
        n_checks++;
        if (next_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL be_glitch_seq: got %h expected %h", next_pc, 32'h300);
        end
        drive(1'b0, 32'h5, 32'h300, 1'b0);
        #1 be = 1'b1;
        to_fall();
        n_checks++;
        if (next_pc !== 32'h314) begin
            n_fail++;
            $display("FAIL be_glitch_taken: got %h expected %h", next_pc, 32'h314);
        end
        // A reset pulse that ends before the falling edge has no effect.
        drive(1'b1, 32'h0, 32'h40, 1'b0);
        #1 rst = 1'b0;
        to_fall();
        n_checks++;
        if (next_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL rst_pulse_between_edges: got %h expected %h", next_pc, 32'h40);
        end
    endtask

    task automatic test_x_be();
        drive(1'b0, 32'h0, 32'h8, 1'bx);
        n_checks++;
        if (next_pc_d !== 32'h8) begin
            n_fail++;
            $display("FAIL x_be next_pc_d: got %h expected %h", next_pc_d, 32'h8);
        end
        to_fall();
        n_checks++;
        if (next_pc !== 32'h8) begin
            n_fail++;
            $display("FAIL x_be next_pc: got %h expected %h", next_pc, 32'h8);
        end
    endtask

    task automatic test_random();
        logic [31:0] os, bt, nd, exp_q;
        logic        r, b;
        logic [31:0] se, pc;
        exp_q = next_pc;
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 7) == 0);
            b  = 1'($urandom_range(0, 1));
            pc = $urandom;
            se = (i % 2 == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
            drive(r, se, pc, b);
            model(se, pc, b, os, bt, nd);
            n_checks++;
            if (offset_shift !== os || branch_target !== bt || next_pc_d !== nd) begin
                n_fail++;
                $display("FAIL rand_comb[%0d]: got os=%h bt=%h nd=%h expected os=%h bt=%h nd=%h",
                         i, offset_shift, branch_target, next_pc_d, os, bt, nd);
            end
            to_fall();
            exp_q = r ? RESET_VALUE : nd;
            n_checks++;
            if (next_pc !== exp_q) begin
                n_fail++;
                $display("FAIL rand_reg[%0d]: got %h expected %h", i, next_pc, exp_q);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        signal_ext = '0;
        pc_plus4   = '0;
        be         = 1'b0;
        test_reset();
        test_forward();
        test_backward();
        test_wrap();
        test_reset_priority();
        test_x_be();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_next_pc_unit
